// File: rtl/cpu_reg_bank_pkg.sv
// rtl/cpu_reg_bank_pkg.sv - shared widths, load-select codes and flag indices for cpu_reg_bank
package cpu_reg_bank_pkg;

    localparam int WORD_SIZE     = 19;
    localparam int ADDR_SIZE     = 20;
    localparam int FLAG_REG_SIZE = 5;

    // Base codes for load_sel; GPR i is selected with LSEL_GPR0 + i
    typedef enum logic [1:0] {
        LSEL_PC   = 2'd0,
        LSEL_IR   = 2'd1,
        LSEL_GPR0 = 2'd2
    } lsel_base_e;

    // Bit positions inside the flag register
    typedef enum logic [2:0] {
        FLAG_ZERO   = 3'd0,
        FLAG_SIGN   = 3'd1,
        FLAG_PARITY = 3'd2,
        FLAG_OVF    = 3'd3,
        FLAG_CARRY  = 3'd4
    } flag_idx_e;

endpackage

// File: rtl/cpu_reg_bank_if.sv
// rtl/cpu_reg_bank_if.sv - control/datapath bus of the register bank with master/slave modports
interface cpu_reg_bank_if #(
    parameter int WORD_SIZE     = cpu_reg_bank_pkg::WORD_SIZE,
    parameter int ADDR_SIZE     = cpu_reg_bank_pkg::ADDR_SIZE,
    parameter int NUM_GPR       = 4,
    parameter int FLAG_REG_SIZE = cpu_reg_bank_pkg::FLAG_REG_SIZE,
    parameter int LSEL_W        = $clog2(NUM_GPR + 2),
    parameter int RADDR_W       = $clog2(NUM_GPR)
);
    logic                     load_en;
    logic [LSEL_W-1:0]        load_sel;
    logic [WORD_SIZE-1:0]     load_data;
    logic                     pc_inc;
    logic [ADDR_SIZE-1:0]     pc_out;
    logic [WORD_SIZE-1:0]     ir_out;
    logic [RADDR_W-1:0]       rd_addr_a;
    logic [RADDR_W-1:0]       rd_addr_b;
    logic [WORD_SIZE-1:0]     rd_data_a;
    logic [WORD_SIZE-1:0]     rd_data_b;
    logic                     flag_we;
    logic [FLAG_REG_SIZE-1:0] flag_in;
    logic                     ovf_clr;
    logic [FLAG_REG_SIZE-1:0] flag_out;

    // Control unit / ALU side
    modport master (
        output load_en, load_sel, load_data, pc_inc, rd_addr_a, rd_addr_b,
               flag_we, flag_in, ovf_clr,
        input  pc_out, ir_out, rd_data_a, rd_data_b, flag_out
    );

    // Register bank side
    modport slave (
        input  load_en, load_sel, load_data, pc_inc, rd_addr_a, rd_addr_b,
               flag_we, flag_in, ovf_clr,
        output pc_out, ir_out, rd_data_a, rd_data_b, flag_out
    );
endinterface

// File: rtl/cpu_reg_bank_pc_counter.sv
// rtl/cpu_reg_bank_pc_counter.sv - load/increment program counter, load wins over increment
module cpu_reg_bank_pc_counter #(
    parameter int WIDTH = cpu_reg_bank_pkg::ADDR_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load suppresses the increment; increment wraps naturally
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_data_i;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/cpu_reg_bank.sv
// rtl/cpu_reg_bank.sv - PC/IR/GPR/flag register bank; CPU_REG_BANK_BYPASS_EN enables write-to-read bypass
module cpu_reg_bank #(
    parameter int WORD_SIZE     = cpu_reg_bank_pkg::WORD_SIZE,
    parameter int ADDR_SIZE     = cpu_reg_bank_pkg::ADDR_SIZE,
    parameter int NUM_GPR       = 4,
    parameter int FLAG_REG_SIZE = cpu_reg_bank_pkg::FLAG_REG_SIZE,
    parameter int LSEL_W        = $clog2(NUM_GPR + 2),
    parameter int RADDR_W       = $clog2(NUM_GPR)
) (
    input  logic          clk,
    input  logic          rst,
    cpu_reg_bank_if.slave bus
);
    import cpu_reg_bank_pkg::*;

    logic [WORD_SIZE-1:0]     ir_q, ir_d;
    logic [WORD_SIZE-1:0]     gpr_q [NUM_GPR];
    logic [WORD_SIZE-1:0]     gpr_d [NUM_GPR];
    logic [FLAG_REG_SIZE-1:0] flag_q, flag_d;
    logic                     pc_load;
    logic                     new_ovf;

    function automatic logic [LSEL_W-1:0] gpr_code(input int idx);
        return LSEL_W'(int'(LSEL_GPR0) + idx);
    endfunction

    // Read addresses beyond the populated GPRs read as zero
    function automatic logic addr_ok(input logic [RADDR_W-1:0] addr);
        return int'(addr) < NUM_GPR;
    endfunction

    assign pc_load = bus.load_en && (bus.load_sel == LSEL_W'(LSEL_PC));

    cpu_reg_bank_pc_counter #(
        .WIDTH(ADDR_SIZE)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_data_i(ADDR_SIZE'(bus.load_data)),
        .inc_i      (bus.pc_inc),
        .count_o    (bus.pc_out)
    );

    // IR and GPR next state; select codes past the last GPR match nothing
    always_comb begin
        ir_d  = ir_q;
        gpr_d = gpr_q;
        if (bus.load_en) begin
            if (bus.load_sel == LSEL_W'(LSEL_IR)) begin
                ir_d = bus.load_data;
            end
            for (int i = 0; i < NUM_GPR; i++) begin
                if (bus.load_sel == gpr_code(i)) begin
                    gpr_d[i] = bus.load_data;
                end
            end
        end
    end

    assign new_ovf = bus.flag_we & bus.flag_in[FLAG_OVF];

    // Flags follow flag_in on a write, except overflow which is sticky until cleared;
    // an overflow raised in the clearing cycle survives the clear
    always_comb begin
        flag_d           = bus.flag_we ? bus.flag_in : flag_q;
        flag_d[FLAG_OVF] = bus.ovf_clr ? new_ovf : (flag_q[FLAG_OVF] | new_ovf);
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q   <= '0;
            flag_q <= '0;
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            ir_q   <= ir_d;
            gpr_q  <= gpr_d;
            flag_q <= flag_d;
        end
    end

    // Operand read ports, combinational from the GPR array
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        if (addr_ok(bus.rd_addr_a)) begin
            bus.rd_data_a = gpr_q[bus.rd_addr_a];
        end
        if (addr_ok(bus.rd_addr_b)) begin
            bus.rd_data_b = gpr_q[bus.rd_addr_b];
        end
`ifdef CPU_REG_BANK_BYPASS_EN
        if (bus.load_en && addr_ok(bus.rd_addr_a) && (bus.load_sel == gpr_code(int'(bus.rd_addr_a)))) begin
            bus.rd_data_a = bus.load_data;
        end
        if (bus.load_en && addr_ok(bus.rd_addr_b) && (bus.load_sel == gpr_code(int'(bus.rd_addr_b)))) begin
            bus.rd_data_b = bus.load_data;
        end
`endif
    end

    assign bus.ir_out   = ir_q;
    assign bus.flag_out = flag_q;
endmodule

// File: tb/tb_cpu_reg_bank.sv
// tb/tb_cpu_reg_bank.sv - directed vector bench for cpu_reg_bank
module tb_cpu_reg_bank;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_reg_bank_if #(.WORD_SIZE(19), .ADDR_SIZE(20), .NUM_GPR(4), .FLAG_REG_SIZE(5)) bus ();
    cpu_reg_bank_if #(.WORD_SIZE(19), .ADDR_SIZE(19), .NUM_GPR(4), .FLAG_REG_SIZE(5)) bus2 ();

    cpu_reg_bank #(.WORD_SIZE(19), .ADDR_SIZE(20), .NUM_GPR(4), .FLAG_REG_SIZE(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Narrow-PC instance: a 19-bit load reaches all-ones, so the wrap is reachable in one step
    cpu_reg_bank #(.WORD_SIZE(19), .ADDR_SIZE(19), .NUM_GPR(4), .FLAG_REG_SIZE(5)) dut_narrow (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    typedef struct {
        string       name;
        logic        load_en;
        logic [2:0]  load_sel;
        logic [18:0] load_data;
        logic        pc_inc;
        logic [1:0]  rd_a;
        logic [1:0]  rd_b;
        logic        flag_we;
        logic [4:0]  flag_in;
        logic        ovf_clr;
        logic [19:0] exp_pc;
        logic [18:0] exp_ir;
        logic [18:0] exp_a;
        logic [18:0] exp_b;
        logic [4:0]  exp_flag;
    } vec_t;

    vec_t vecs [15];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.load_en   = 1'b0;
        bus.load_sel  = '0;
        bus.load_data = '0;
        bus.pc_inc    = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.flag_we   = 1'b0;
        bus.flag_in   = '0;
        bus.ovf_clr   = 1'b0;
        bus2.load_en   = 1'b0;
        bus2.load_sel  = '0;
        bus2.load_data = '0;
        bus2.pc_inc    = 1'b0;
        bus2.rd_addr_a = '0;
        bus2.rd_addr_b = '0;
        bus2.flag_we   = 1'b0;
        bus2.flag_in   = '0;
        bus2.ovf_clr   = 1'b0;
    endtask

    initial begin
        //                name          en sel  data       inc ra rb we fin       clr pc        ir        a         b         flag
        vecs[0]  = '{"gpr0_wr",     1, 3'd2, 19'h00011, 0, 0, 1, 0, 5'b00000, 0, 20'h0,     19'h0,     19'h00011, 19'h0,     5'h00};
        vecs[1]  = '{"gpr1_wr",     1, 3'd3, 19'h00222, 0, 0, 1, 0, 5'b00000, 0, 20'h0,     19'h0,     19'h00011, 19'h00222, 5'h00};
        vecs[2]  = '{"gpr3_max",    1, 3'd5, 19'h7FFFF, 0, 3, 2, 0, 5'b00000, 0, 20'h0,     19'h0,     19'h7FFFF, 19'h0,     5'h00};
        vecs[3]  = '{"sel7_ign",    1, 3'd7, 19'h55555, 0, 3, 0, 0, 5'b00000, 0, 20'h0,     19'h0,     19'h7FFFF, 19'h00011, 5'h00};
        vecs[4]  = '{"sel6_ign",    1, 3'd6, 19'h2AAAA, 0, 1, 3, 0, 5'b00000, 0, 20'h0,     19'h0,     19'h00222, 19'h7FFFF, 5'h00};
        vecs[5]  = '{"ir_wr",       1, 3'd1, 19'h4ABCD, 0, 0, 1, 0, 5'b00000, 0, 20'h0,     19'h4ABCD, 19'h00011, 19'h00222, 5'h00};
        vecs[6]  = '{"pc_load",     1, 3'd0, 19'h7FFFF, 0, 0, 1, 0, 5'b00000, 0, 20'h7FFFF, 19'h4ABCD, 19'h00011, 19'h00222, 5'h00};
        vecs[7]  = '{"pc_inc_carry",0, 3'd0, 19'h0,     1, 0, 1, 0, 5'b00000, 0, 20'h80000, 19'h4ABCD, 19'h00011, 19'h00222, 5'h00};
        vecs[8]  = '{"pc_ld_beats", 1, 3'd0, 19'h00005, 1, 0, 1, 0, 5'b00000, 0, 20'h5,     19'h4ABCD, 19'h00011, 19'h00222, 5'h00};
        vecs[9]  = '{"flag_ovf",    0, 3'd0, 19'h0,     0, 0, 1, 1, 5'b01000, 0, 20'h5,     19'h4ABCD, 19'h00011, 19'h00222, 5'h08};
        vecs[10] = '{"flag_sticky", 0, 3'd0, 19'h0,     0, 0, 1, 1, 5'b00001, 0, 20'h5,     19'h4ABCD, 19'h00011, 19'h00222, 5'h09};
        vecs[11] = '{"ovf_clr",     0, 3'd0, 19'h0,     0, 0, 1, 0, 5'b00000, 1, 20'h5,     19'h4ABCD, 19'h00011, 19'h00222, 5'h01};
        vecs[12] = '{"ovf_clr_new", 0, 3'd0, 19'h0,     0, 0, 1, 1, 5'b01000, 1, 20'h5,     19'h4ABCD, 19'h00011, 19'h00222, 5'h08};
        vecs[13] = '{"concurrent",  1, 3'd1, 19'h12345, 1, 0, 1, 1, 5'b10110, 0, 20'h6,     19'h12345, 19'h00011, 19'h00222, 5'h1E};
        vecs[14] = '{"gpr2_flag0",  1, 3'd4, 19'h0ABCD, 0, 2, 3, 1, 5'b00000, 0, 20'h6,     19'h12345, 19'h0ABCD, 19'h7FFFF, 5'h08};

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pc", 32'(bus.pc_out), 32'h0);
        chk("rst_ir", 32'(bus.ir_out), 32'h0);
        chk("rst_flag", 32'(bus.flag_out), 32'h0);
        chk("rst_rd_a", 32'(bus.rd_data_a), 32'h0);
        chk("rst_pc_narrow", 32'(bus2.pc_out), 32'h0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.load_en   = vecs[i].load_en;
            bus.load_sel  = vecs[i].load_sel;
            bus.load_data = vecs[i].load_data;
            bus.pc_inc    = vecs[i].pc_inc;
            bus.rd_addr_a = vecs[i].rd_a;
            bus.rd_addr_b = vecs[i].rd_b;
            bus.flag_we   = vecs[i].flag_we;
            bus.flag_in   = vecs[i].flag_in;
            bus.ovf_clr   = vecs[i].ovf_clr;
            @(posedge clk);
            #1;
            idle();
            bus.rd_addr_a = vecs[i].rd_a;
            bus.rd_addr_b = vecs[i].rd_b;
            #1;
            chk({vecs[i].name, ".pc"},   32'(bus.pc_out),    32'(vecs[i].exp_pc));
            chk({vecs[i].name, ".ir"},   32'(bus.ir_out),    32'(vecs[i].exp_ir));
            chk({vecs[i].name, ".a"},    32'(bus.rd_data_a), 32'(vecs[i].exp_a));
            chk({vecs[i].name, ".b"},    32'(bus.rd_data_b), 32'(vecs[i].exp_b));
            chk({vecs[i].name, ".flag"}, 32'(bus.flag_out),  32'(vecs[i].exp_flag));
        end

        // pc_inc held for 10 cycles advances PC from 6 to 16
        @(negedge clk);
        bus.pc_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.pc_inc = 1'b0;
        chk("pc_hold10", 32'(bus.pc_out), 32'h10);

        // Reset with every write path active at the same time
        @(negedge clk);
        rst           = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_sel  = 3'd2;
        bus.load_data = 19'h3C3C3;
        bus.pc_inc    = 1'b1;
        bus.flag_we   = 1'b1;
        bus.flag_in   = 5'b11111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        #1;
        chk("rstw_pc", 32'(bus.pc_out), 32'h0);
        chk("rstw_ir", 32'(bus.ir_out), 32'h0);
        chk("rstw_flag", 32'(bus.flag_out), 32'h0);
        chk("rstw_gpr0", 32'(bus.rd_data_a), 32'h0);
        bus.rd_addr_a = 2'd2;
        bus.rd_addr_b = 2'd3;
        #1;
        chk("rstw_gpr2", 32'(bus.rd_data_a), 32'h0);
        chk("rstw_gpr3", 32'(bus.rd_data_b), 32'h0);

        // Same-cycle write and read of GPR1
        @(negedge clk);
        bus.rd_addr_b = 2'd1;
        bus.load_en   = 1'b1;
        bus.load_sel  = 3'd3;
        bus.load_data = 19'h12345;
        #1;
`ifdef CPU_REG_BANK_BYPASS_EN
        chk("bypass_same_cycle", 32'(bus.rd_data_b), 32'h12345);
`else
        chk("nobypass_same_cycle", 32'(bus.rd_data_b), 32'h0);
`endif
        @(posedge clk);
        #1;
        bus.load_en = 1'b0;
        #1;
        chk("bypass_next_cycle", 32'(bus.rd_data_b), 32'h12345);

        // Narrow PC: load all-ones, then one increment wraps to zero
        @(negedge clk);
        bus2.load_en   = 1'b1;
        bus2.load_sel  = 3'd0;
        bus2.load_data = 19'h7FFFF;
        @(posedge clk);
        #1;
        bus2.load_en = 1'b0;
        chk("narrow_pc_max", 32'(bus2.pc_out), 32'h7FFFF);
        @(negedge clk);
        bus2.pc_inc = 1'b1;
        @(posedge clk);
        #1;
        bus2.pc_inc = 1'b0;
        chk("narrow_pc_wrap", 32'(bus2.pc_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_reg_bank.md
# cpu_reg_bank

Parametrised architectural register bank for the 19-bit CPU. It replaces the fixed PC/IR/A/B/C load-select scheme with a bank of NUM_GPR general-purpose registers. It adds an incrementing program counter, an instruction register, and an ALU flag register with a sticky overflow bit. It sits between the control unit, which drives load select and PC increment, and the ALU/datapath, which reads two operands and writes flags.

## Interface
Parameters:
- WORD_SIZE, 19, data/instruction width
- ADDR_SIZE, 20, program counter width
- NUM_GPR, 4, number of general-purpose registers (≥2)
- FLAG_REG_SIZE, 5, flag register width: zero, sign, parity, overflow, carry
- LSEL_W, $clog2(NUM_GPR+2), load-select width (derived)
- RADDR_W, $clog2(NUM_GPR), GPR read-address width (derived)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load_en  in  1  write strobe for the target chosen by load_sel
- load_sel  in  LSEL_W  0 = PC, 1 = IR, 2+i = GPR i
- load_data  in  WORD_SIZE  write data
- pc_inc  in  1  increment PC by 1
- pc_out  out  ADDR_SIZE  program counter
- ir_out  out  WORD_SIZE  instruction register
- rd_addr_a / rd_addr_b  in  RADDR_W  operand read addresses
- rd_data_a / rd_data_b  out  WORD_SIZE  operand read data
- flag_we  in  1  flag register write strobe
- flag_in  in  FLAG_REG_SIZE  new flags from ALU
- ovf_clr  in  1  clear sticky overflow
- flag_out  out  FLAG_REG_SIZE  flag register

## Operation
- Reset: PC, IR, all GPRs and flags are 0 on the first edge with rst=1. rst overrides every concurrent write, increment and clear.
- Load: on an edge with load_en=1, the target selected by load_sel takes load_data.
  - PC load zero-extends load_data to ADDR_SIZE.
  - load_sel ≥ NUM_GPR+2 is ignored; no state changes.
- PC increment: pc_inc=1 gives PC ← PC+1 modulo 2^ADDR_SIZE. All-ones wraps to 0.
- PC precedence: PC load beats pc_inc in the same cycle; no increment occurs.
- Read ports: combinational from the GPR array. rd_addr ≥ NUM_GPR returns 0.
- Flag indices: zero 0, sign 1, parity 2, overflow 3, carry 4.
- flag_we=1: bits other than overflow take flag_in.
- Overflow bit, next value:
  - if ovf_clr=1: flag_we & flag_in[3]
  - otherwise: ovf | (flag_we & flag_in[3])
  - A new overflow in the clearing cycle is therefore kept.
- Flag and load writes are independent and may happen in the same cycle.

## Timing
- Write to visible output: 1 cycle. pc_out, ir_out and flag_out change on the edge after the strobe.
- Read latency: 0 cycles, combinational from state.
- Same-cycle write/read of the same GPR: behaviour depends on the macro below.
- pc_inc held for N cycles advances PC by N.

## Configuration
- Macro: CPU_REG_BANK_BYPASS_EN.
- Defined: write-to-read bypass. If load_en=1, load_sel=2+i and rd_addr_x=i, then rd_data_x = load_data in that same cycle. The path is combinational from load_data.
- Undefined: rd_data_x returns the old value until the edge. There is no combinational path from load_data to rd_data.

## Structure
- Shared package: WORD_SIZE, ADDR_SIZE, FLAG_REG_SIZE, the load-select base codes (LSEL_PC=0, LSEL_IR=1, LSEL_GPR0=2) as a typedef enum, and the flag-index enum (ZERO..CARRY).
- Sub-module pc_counter: ADDR_SIZE-wide load/increment counter with load-over-increment priority, reused by the fetch unit.

## Test plan
- Reset: write all registers with nonzero values, then assert rst for 1 cycle together with load_en → every output is 0 on the next cycle.
- GPR write/read: write 19'h7FFFF to GPR3 (load_sel=5), then read rd_addr_a=3 → 19'h7FFFF. Write with load_sel=7 (NUM_GPR=4) → no register changes.
- PC wrap and priority:
  - load PC with 19'h7FFFF → pc_out = 20'h7FFFF
  - drive pc_inc for 2^20−0x7FFFF cycles → pc_out = 0
  - load with pc_inc=1 and load_data=5 → pc_out = 5
- Sticky overflow:
  - flag_we with flag_in=5'b01000, then flag_we with 5'b00001 → flag_out = 5'b01001
  - ovf_clr alone → 5'b00001
  - ovf_clr together with flag_we and 5'b01000 → 5'b01000
- Bypass: write GPR1 = 19'h12345 while rd_addr_b=1. With the macro defined, rd_data_b = 19'h12345 in the same cycle. Without it, rd_data_b shows the old value until the next cycle.
- Concurrent paths: IR load, pc_inc and flag_we in one cycle → all three update together with no interference.
